// File: rtl/anim_sequencer_if.sv
// Sprite-sheet frame table lookup bus.
// The sequencer (master) presents the animation ID and frame index, and the
// table (slave) returns that frame's geometry, hold count and sequencing flags
// combinationally.
// Optional build macro: ANIM_HITBOX_EN adds the per-frame tbl_hit flag.
interface anim_tbl_if #(
    parameter int NUM_ANIMS  = 8,
    parameter int MAX_FRAMES = 8,
    parameter int POS_W      = 11,
    parameter int WID_W      = 6,
    parameter int HOLD_W     = 4
);
    localparam int AW = $clog2(NUM_ANIMS);
    localparam int FW = $clog2(MAX_FRAMES);

    logic [AW-1:0]     tbl_anim;
    logic [FW-1:0]     tbl_frame;
    logic [POS_W-1:0]  tbl_row;
    logic [POS_W-1:0]  tbl_col;
    logic [WID_W-1:0]  tbl_width;
    logic [HOLD_W-1:0] tbl_hold;
    logic              tbl_last;
    logic              tbl_loop;
`ifdef ANIM_HITBOX_EN
    logic              tbl_hit;
`endif

    modport master (
        output tbl_anim, tbl_frame,
        input  tbl_row, tbl_col, tbl_width, tbl_hold, tbl_last, tbl_loop
`ifdef ANIM_HITBOX_EN
        , input tbl_hit
`endif
    );

    modport slave (
        input  tbl_anim, tbl_frame,
        output tbl_row, tbl_col, tbl_width, tbl_hold, tbl_last, tbl_loop
`ifdef ANIM_HITBOX_EN
        , output tbl_hit
`endif
    );
endinterface

// File: rtl/anim_sequencer.sv
// Table-driven sprite animation sequencer.
// Plays the requested movement animation, or a latched one-shot override,
// frame by frame on anim_tick, and registers the looked-up sheet geometry.
// Optional build macro: ANIM_HITBOX_EN adds the hitbox_active output.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_PLAY | animation advancing on ticks (hold count, next frame, wrap)
// ST_DONE | one-shot finished; last frame frozen until the selection moves
module anim_sequencer #(
    parameter int   NUM_ANIMS  = 8,
    parameter int   MAX_FRAMES = 8,
    parameter int   POS_W      = 11,
    parameter int   WID_W      = 6,
    parameter int   HOLD_W     = 4,
    localparam int  AW         = $clog2(NUM_ANIMS),
    localparam int  FW         = $clog2(MAX_FRAMES)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             anim_tick,
    input  logic [AW-1:0]    req_anim,
    input  logic             ovr_valid,
    input  logic [AW-1:0]    ovr_anim,
    output logic             ovr_busy,
    anim_tbl_if.master       tbl,
    output logic [AW-1:0]    cur_anim,
    output logic [FW-1:0]    frame_idx,
    output logic [POS_W-1:0] anim_row,
    output logic [POS_W-1:0] anim_col,
    output logic [WID_W-1:0] max_width,
    output logic             anim_done
`ifdef ANIM_HITBOX_EN
    , output logic           hitbox_active
`endif
);

    typedef enum logic [0:0] {ST_PLAY, ST_DONE} state_t;

    state_t            state_q, state_nxt;
    logic [HOLD_W-1:0] hold_q, hold_nxt;
    logic [AW-1:0]     cur_nxt;
    logic [FW-1:0]     frame_nxt;
    logic              done_nxt;
    logic              ovr_clr;
    logic              ovr_active;
    logic [AW-1:0]     ovr_id;
    logic [AW-1:0]     eff_anim;
    logic              is_last;

    // The registered override flag selects the source, so a strobe coincident
    // with a tick only takes effect on the following tick.
    assign eff_anim = ovr_active ? ovr_id : req_anim;
    assign is_last  = tbl.tbl_last || (frame_idx == FW'(MAX_FRAMES - 1));
    assign ovr_busy = ovr_active;

    assign tbl.tbl_anim  = cur_anim;
    assign tbl.tbl_frame = frame_idx;

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_PLAY;
            cur_anim  <= '0;
            frame_idx <= '0;
            hold_q    <= '0;
            anim_done <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cur_anim  <= cur_nxt;
            frame_idx <= frame_nxt;
            hold_q    <= hold_nxt;
            anim_done <= done_nxt;
        end
    end

    // Per-tick decision, highest priority first: switch, frozen, hold, advance, wrap, finish.
    always_comb begin
        state_nxt = state_q;
        cur_nxt   = cur_anim;
        frame_nxt = frame_idx;
        hold_nxt  = hold_q;
        done_nxt  = 1'b0;
        ovr_clr   = 1'b0;
        if (anim_tick) begin
            if (eff_anim != cur_anim) begin
                cur_nxt   = eff_anim;
                frame_nxt = '0;
                hold_nxt  = '0;
                state_nxt = ST_PLAY;
            end else if (state_q == ST_DONE) begin
                state_nxt = ST_DONE;
            end else if (hold_q < tbl.tbl_hold) begin
                hold_nxt = hold_q + 1'b1;
            end else if (!is_last) begin
                frame_nxt = frame_idx + 1'b1;
                hold_nxt  = '0;
            end else if (tbl.tbl_loop) begin
                frame_nxt = '0;
                hold_nxt  = '0;
            end else begin
                state_nxt = ST_DONE;
                done_nxt  = 1'b1;
                ovr_clr   = ovr_active;
            end
        end
    end

    // Override latch: first strobe wins, later strobes are dropped until completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovr_active <= 1'b0;
            ovr_id     <= '0;
        end else if (ovr_clr) begin
            ovr_active <= 1'b0;
        end else if (ovr_valid && !ovr_active) begin
            ovr_active <= 1'b1;
            ovr_id     <= ovr_anim;
        end
    end

    // Register the table return every clock; outputs trail the lookup by one clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            anim_row  <= '0;
            anim_col  <= '0;
            max_width <= '0;
        end else begin
            anim_row  <= tbl.tbl_row;
            anim_col  <= tbl.tbl_col;
            max_width <= tbl.tbl_width;
        end
    end

`ifdef ANIM_HITBOX_EN
    // Hitbox follows the frame flag, suppressed while a finished one-shot is frozen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hitbox_active <= 1'b0;
        end else begin
            hitbox_active <= (state_q == ST_DONE) ? 1'b0 : tbl.tbl_hit;
        end
    end
`endif

endmodule
